// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the pipe_stage skid-buffered pipeline register:
// occupancy state encoding and default widths.
package pipe_stage_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CTRL_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage : pipe_stage_pkg

// File: rtl/pipe_stage_reg.sv
// stage_reg: enabled storage register for one pipeline entry (payload + control),
// cleared asynchronously.
module stage_reg #(
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Entry storage, loaded only when enabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= {WIDTH{1'b0}};
        end else if (en) begin
            q <= d;
        end
    end

endmodule : stage_reg

// File: rtl/pipe_stage.sv
// pipe_stage: two-entry (main + skid) pipeline stage with a valid/ready handshake
// on both sides, flush, and a saturating backpressure counter.
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CTRL_WIDTH = DEF_CTRL_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  up_valid,
    output logic                  up_ready,
    input  logic [DATA_WIDTH-1:0] up_data,
    input  logic [CTRL_WIDTH-1:0] up_ctrl,
    input  logic                  flush,
    output logic                  dn_valid,
    input  logic                  dn_ready,
    output logic [DATA_WIDTH-1:0] dn_data,
    output logic [CTRL_WIDTH-1:0] dn_ctrl,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    localparam int REG_WIDTH = DATA_WIDTH + CTRL_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_r;
    state_t               state_next_s;
    logic                 up_xfer_s;
    logic                 dn_xfer_s;
    logic                 main_en_s;
    logic                 skid_en_s;
    logic [REG_WIDTH-1:0] up_word_s;
    logic [REG_WIDTH-1:0] main_d_s;
    logic [REG_WIDTH-1:0] main_q_s;
    logic [REG_WIDTH-1:0] skid_q_s;
    logic [CNT_WIDTH-1:0] stall_r;

    // Both handshake flags decode the state register only, so up_ready never sees dn_ready
    assign up_ready  = (state_r != FULL);
    assign dn_valid  = (state_r != EMPTY);
    assign up_xfer_s = up_valid & up_ready;
    assign dn_xfer_s = dn_valid & dn_ready;
    assign up_word_s = {up_ctrl, up_data};

    // Next-state and storage-enable decode; flush squashes everything held or offered
    always_comb begin
        state_next_s = state_r;
        main_en_s    = 1'b0;
        skid_en_s    = 1'b0;
        main_d_s     = up_word_s;
        if (flush) begin
            state_next_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (up_xfer_s) begin
                        main_en_s    = 1'b1;
                        state_next_s = BUSY;
                    end else begin
                        state_next_s = EMPTY;
                    end
                end
                BUSY: begin
                    if (up_xfer_s && dn_xfer_s) begin
                        main_en_s    = 1'b1;
                        state_next_s = BUSY;
                    end else if (dn_xfer_s) begin
                        state_next_s = EMPTY;
                    end else if (up_xfer_s) begin
                        skid_en_s    = 1'b1;
                        state_next_s = FULL;
                    end else begin
                        state_next_s = BUSY;
                    end
                end
                FULL: begin
                    if (dn_xfer_s) begin
                        main_en_s    = 1'b1;
                        main_d_s     = skid_q_s;
                        state_next_s = BUSY;
                    end else begin
                        state_next_s = FULL;
                    end
                end
                default: begin
                    state_next_s = EMPTY;
                end
            endcase
        end
    end

    // Occupancy state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Saturating count of cycles the head entry waits on downstream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_r <= {CNT_WIDTH{1'b0}};
        end else if (dn_valid && !dn_ready && (stall_r != CNT_MAX)) begin
            stall_r <= stall_r + CNT_ONE;
        end else begin
            stall_r <= stall_r;
        end
    end

    stage_reg #(.WIDTH(REG_WIDTH)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en_s),
        .d   (main_d_s),
        .q   (main_q_s)
    );

    stage_reg #(.WIDTH(REG_WIDTH)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en_s),
        .d   (up_word_s),
        .q   (skid_q_s)
    );

    assign dn_data   = main_q_s[DATA_WIDTH-1:0];
    assign dn_ctrl   = dn_valid ? main_q_s[REG_WIDTH-1:DATA_WIDTH] : {CTRL_WIDTH{1'b0}};
    assign stall_cnt = stall_r;

endmodule : pipe_stage

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage: a driver records accepted entries in a FIFO
// model (capacity 2), a negedge monitor checks the DUT against it.
module tb_pipe_stage;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NW = 4;
    localparam int SAT = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          up_valid = 1'b0;
    logic          up_ready;
    logic [DW-1:0] up_data = '0;
    logic [CW-1:0] up_ctrl = '0;
    logic          flush = 1'b0;
    logic          dn_valid;
    logic          dn_ready = 1'b0;
    logic [DW-1:0] dn_data;
    logic [CW-1:0] dn_ctrl;
    logic [NW-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    logic [DW+CW-1:0] exp_q[$];
    logic             pend_acc = 1'b0;
    logic             pend_flush = 1'b0;
    logic [DW+CW-1:0] pend_item = '0;
    int               stall_m = 0;

    pipe_stage #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .up_data   (up_data),
        .up_ctrl   (up_ctrl),
        .flush     (flush),
        .dn_valid  (dn_valid),
        .dn_ready  (dn_ready),
        .dn_data   (dn_data),
        .dn_ctrl   (dn_ctrl),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: settle the model for the edge just taken, then drive.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic r, input logic f);
        @(posedge clk);
        if (pend_flush) exp_q.delete();
        else if (pend_acc) exp_q.push_back(pend_item);
        #1;
        up_valid   = v;
        up_data    = d;
        up_ctrl    = c;
        dn_ready   = r;
        flush      = f;
        pend_acc   = v && (exp_q.size() < 2) && !f;
        pend_flush = f;
        pend_item  = {c, d};
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, r, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dn_valid"}, 64'(dn_valid), 64'd0);
        check({tag, "_up_ready"}, 64'(up_ready), 64'd1);
        check({tag, "_dn_data"}, 64'(dn_data), 64'd0);
        check({tag, "_dn_ctrl"}, 64'(dn_ctrl), 64'd0);
        check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
    endtask

    // Monitor: compare flags, head entry and stall count against the model
    always @(negedge clk) begin
        if (rst) begin
            int held;
            held = exp_q.size();
            check("up_ready", 64'(up_ready), 64'(held < 2));
            check("dn_valid", 64'(dn_valid), 64'(held != 0));
            check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
            if (held == 0) begin
                check("dn_ctrl_idle", 64'(dn_ctrl), 64'd0);
            end else begin
                check("dn_data", 64'(dn_data), 64'(exp_q[0][DW-1:0]));
                check("dn_ctrl", 64'(dn_ctrl), 64'(exp_q[0][DW+CW-1:DW]));
                if (dn_ready) void'(exp_q.pop_front());
                else if (stall_m < SAT) stall_m++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check_reset_values("reset");
        @(negedge clk);
        #1 rst = 1'b1;

        // streaming at full rate
        cycle(1'b1, 32'h11, 8'h01, 1'b1, 1'b0);
        cycle(1'b1, 32'h22, 8'h02, 1'b1, 1'b0);
        cycle(1'b1, 32'h33, 8'h03, 1'b1, 1'b0);
        idle(3, 1'b1);
        check("stream_stall", 64'(stall_cnt), 64'd0);

        // backpressure fills main and skid
        cycle(1'b1, 32'hA, 8'h0A, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 8'h0B, 1'b0, 1'b0);
        cycle(1'b1, 32'hD, 8'h0D, 1'b0, 1'b0);
        check("bp_full_up_ready", 64'(up_ready), 64'd0);
        idle(4, 1'b1);
        check("bp_stall_ge2", 64'(stall_cnt >= 4'd2), 64'd1);

        // flush while full, with a new entry offered
        cycle(1'b1, 32'h1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 32'h2, 8'h12, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 8'h1C, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check("flush_dn_valid", 64'(dn_valid), 64'd0);
        check("flush_dn_ctrl", 64'(dn_ctrl), 64'd0);
        idle(3, 1'b1);

        // saturation of the stall counter
        cycle(1'b1, 32'h55, 8'h55, 1'b0, 1'b0);
        idle(21, 1'b0);
        check("sat_stall", 64'(stall_cnt), 64'd15);
        idle(2, 1'b1);

        // asynchronous reset mid-cycle while full
        cycle(1'b1, 32'h66, 8'h66, 1'b0, 1'b0);
        cycle(1'b1, 32'h77, 8'h77, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        check("pre_reset_full", 64'(up_ready), 64'd0);
        #2 rst = 1'b0;
        #1;
        check_reset_values("async");
        exp_q.delete();
        pend_acc = 1'b0;
        pend_flush = 1'b0;
        stall_m = 0;
        up_valid = 1'b0;
        dn_ready = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;

        // randomized traffic
        for (int i = 0; i < 10000; i++) begin
            logic v, r, f;
            v = ($urandom_range(3, 0) != 0);
            r = ((i / 500) % 2 == 0) ? ($urandom_range(2, 0) != 0) : ($urandom_range(3, 0) == 0);
            f = ($urandom_range(63, 0) == 0);
            cycle(v, DW'($urandom), CW'($urandom), r, f);
        end
        idle(4, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipe_stage
